// File: rtl/vend_pkg.sv
// vend_pkg: shared coin denominations, hopper indices and change-dispenser state encoding
package vend_pkg;
   localparam logic [1:0] HOP_50 = 2'd0;
   localparam logic [1:0] HOP_10 = 2'd1;
   localparam logic [1:0] HOP_5  = 2'd2;
   localparam logic [1:0] HOP_1  = 2'd3;
   localparam logic [7:0] DENOM_50 = 8'd50;
   localparam logic [7:0] DENOM_10 = 8'd10;
   localparam logic [7:0] DENOM_5  = 8'd5;
   localparam logic [7:0] DENOM_1  = 8'd1;
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SELECT   = 2'd1,
      ST_DISPENSE = 2'd2,
      ST_DONE     = 2'd3
   } state_t;
   function automatic logic [7:0] denom(input logic [1:0] idx);
      return idx == HOP_50 ? DENOM_50 : idx == HOP_10 ? DENOM_10 : idx == HOP_5 ? DENOM_5 : DENOM_1;
   endfunction
endpackage

// File: rtl/vend_denom_select.sv
// vend_denom_select: greedy picker of the largest usable coin hopper for the remaining amount
module vend_denom_select
   import vend_pkg::*;
#(
   parameter int AMT_W = 16,
   parameter int CNT_W = 8
) (
   input  logic [AMT_W-1:0]   i_remaining,
   input  logic [4*CNT_W-1:0] i_counts,
   input  logic [3:0]         i_fault,
   output logic               o_valid,
   output logic [1:0]         o_index
);
   // Scan from the smallest coin upward so the last hit is the largest eligible one
   always_comb begin
      o_valid = 1'b0;
      o_index = 2'd0;
      for (int k = 3; k >= 0; k--)
         if (AMT_W'(denom(2'(k))) <= i_remaining && i_counts[k*CNT_W +: CNT_W] != '0 && !i_fault[k]) begin
            o_valid = 1'b1;
            o_index = 2'(k);
         end
   end
endmodule

// File: rtl/vend_change_dispenser.sv
// vend_change_dispenser: sequences the coin hoppers to pay out change with timeout fault handling
module vend_change_dispenser
   import vend_pkg::*;
#(
   parameter int AMT_W      = 16,
   parameter int CNT_W      = 8,
   parameter int INIT_COUNT = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic               CLOCK,
   input  logic               CLEAR,
   input  logic               change_req,
   input  logic [AMT_W-1:0]   change_amount,
   output logic               hopper_req,
   output logic [1:0]         hopper_sel,
   input  logic               hopper_ack,
   output logic               busy,
   output logic               done,
   output logic [AMT_W-1:0]   dispensed_total,
   output logic [AMT_W-1:0]   shortfall,
   output logic [3:0]         fault,
   input  logic               refill_valid,
   input  logic [1:0]         refill_sel,
   input  logic [CNT_W-1:0]   refill_qty,
   output logic               refill_ready,
   output logic [4*CNT_W-1:0] inv_count
);
   localparam int TW = $clog2(TIMEOUT + 1);
   state_t             r_state, w_next;
   logic [AMT_W-1:0]   r_rem, r_tot, r_short;
   logic [1:0]         r_sel;
   logic [TW-1:0]      r_tmr;
   logic [4*CNT_W-1:0] r_inv;
   logic [3:0]         r_fault;
   logic               w_valid, w_tmo;
   logic [1:0]         w_idx;
   logic [AMT_W-1:0]   w_denom;
   logic [CNT_W-1:0]   w_ref_old, w_cur_cnt, w_ref_new;
   logic [CNT_W:0]     w_ref_sum;

   vend_denom_select #(.AMT_W(AMT_W), .CNT_W(CNT_W)) u_sel (
      .i_remaining(r_rem),
      .i_counts   (r_inv),
      .i_fault    (r_fault),
      .o_valid    (w_valid),
      .o_index    (w_idx)
   );

   assign w_denom   = AMT_W'(denom(r_sel));
   assign w_tmo     = r_tmr == TW'(TIMEOUT - 1);
   assign w_cur_cnt = r_inv[r_sel*CNT_W +: CNT_W];
   assign w_ref_old = r_inv[refill_sel*CNT_W +: CNT_W];
   assign w_ref_sum = {1'b0, w_ref_old} + {1'b0, refill_qty};
   assign w_ref_new = w_ref_sum[CNT_W] ? '1 : w_ref_sum[CNT_W-1:0];

   assign hopper_req      = r_state == ST_DISPENSE;
   assign hopper_sel      = r_sel;
   assign busy            = r_state != ST_IDLE;
   assign done            = r_state == ST_DONE;
   assign refill_ready    = r_state == ST_IDLE;
   assign dispensed_total = r_tot;
   assign shortfall       = r_short;
   assign fault           = r_fault;
   assign inv_count       = r_inv;

   // State register
   always_ff @(posedge CLOCK or negedge CLEAR)
      if (!CLEAR) r_state <= ST_IDLE;
      else        r_state <= w_next;

   // Next-state: one coin attempt per SELECT/DISPENSE pair; an ack on the timeout cycle still pays
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:     w_next = change_req ? ST_SELECT : ST_IDLE;
         ST_SELECT:   w_next = (r_rem == '0 || !w_valid) ? ST_DONE : ST_DISPENSE;
         ST_DISPENSE: w_next = (hopper_ack || w_tmo) ? ST_SELECT : ST_DISPENSE;
         ST_DONE:     w_next = ST_IDLE;
      endcase
   end

   // Payout datapath: amounts, inventory, timeout timer and sticky faults
   always_ff @(posedge CLOCK or negedge CLEAR)
      if (!CLEAR) begin
         r_rem   <= '0;
         r_tot   <= '0;
         r_short <= '0;
         r_sel   <= 2'd0;
         r_tmr   <= '0;
         r_inv   <= {4{CNT_W'(INIT_COUNT)}};
         r_fault <= 4'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (refill_valid) begin
                  r_inv[refill_sel*CNT_W +: CNT_W] <= w_ref_new;
                  r_fault[refill_sel]              <= 1'b0;
               end
               if (change_req) begin
                  r_rem   <= change_amount;
                  r_tot   <= '0;
                  r_short <= '0;
               end
            end
            ST_SELECT: begin
               r_tmr <= '0;
               if (r_rem != '0 && w_valid) r_sel   <= w_idx;
               else if (r_rem != '0)       r_short <= r_rem;
            end
            ST_DISPENSE: begin
               r_tmr <= r_tmr + TW'(1);
               if (hopper_ack) begin
                  r_inv[r_sel*CNT_W +: CNT_W] <= w_cur_cnt - CNT_W'(1);
                  r_rem <= r_rem - w_denom;
                  r_tot <= r_tot + w_denom;
               end else if (w_tmo) r_fault[r_sel] <= 1'b1;
            end
            default: ;
         endcase
      end
endmodule

// File: doc/vend_change_dispenser.md
Name: vend_change_dispenser

Overview:
- Sequences the vending machine's four coin hoppers (50, 10, 5, 1) to pay out a change amount requested by the vending FSM.
- Picks coins greedily, largest first, limited by per-hopper inventory.
- Handles the hopper req/ack handshake with a timeout that marks a hopper faulty.
- Reports any shortfall when the inventory cannot cover the full amount.

Parameters:
AMT_W, 16, width of change amounts and totals
CNT_W, 8, width of each hopper inventory counter
INIT_COUNT, 4, inventory loaded into every hopper at reset
TIMEOUT, 16, cycles allowed in DISPENSE for hopper_ack before a fault is declared

Ports:
CLOCK  in  1  system clock, rising edge
CLEAR  in  1  asynchronous, active-low reset
change_req  in  1  start request; sampled only in IDLE
change_amount  in  AMT_W  amount to pay out; latched with change_req
hopper_req  out  1  dispense one coin from hopper_sel
hopper_sel  out  2  0=50, 1=10, 2=5, 3=1
hopper_ack  in  1  hopper has released one coin
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of payout
dispensed_total  out  AMT_W  value paid in the current/last payout
shortfall  out  AMT_W  unpaid remainder of the last payout
fault  out  4  sticky per-hopper timeout flags, same indexing as hopper_sel
refill_valid  in  1  refill request
refill_sel  in  2  hopper to refill
refill_qty  in  CNT_W  coins added
refill_ready  out  1  high only in IDLE
inv_count  out  4*CNT_W  inventory, hopper i at bits [i*CNT_W +: CNT_W]

Behaviour:
- Reset (CLEAR=0, asynchronous): state=IDLE; all counts=INIT_COUNT; fault=0.
  - hopper_req, done, busy = 0; dispensed_total, shortfall = 0.
  - Reset asserted mid-payout aborts it immediately; no done pulse is generated.
- States: IDLE, SELECT, DISPENSE, DONE. Encoding is in the package.
- IDLE:
  - On change_req=1: latch remaining=change_amount; clear dispensed_total and shortfall; go to SELECT.
  - change_req outside IDLE is ignored.
- SELECT (1 cycle): choose the first hopper in order 0..3 with all three true: denomination <= remaining, count != 0, fault bit clear.
  - remaining==0 -> DONE.
  - No eligible hopper -> shortfall=remaining, then DONE.
  - Otherwise register hopper_sel, clear the timeout counter, go to DISPENSE.
- DISPENSE: hopper_req=1 and hopper_sel held stable for the whole state.
  - hopper_ack is sampled only while hopper_req=1.
  - On ack: count[sel]-=1; remaining-=denom; dispensed_total+=denom; go to SELECT.
  - No ack and timer reaches TIMEOUT-1: set fault[sel]; go to SELECT with no coin accounted.
  - An ack arriving on the timeout cycle wins: the coin is counted and no fault is set.
- DONE: done=1 for exactly one cycle, then IDLE. dispensed_total and shortfall hold until the next accepted request.
- Minimum latency per coin: 2 cycles (SELECT + DISPENSE with immediate ack).
- Zero-amount request: IDLE -> SELECT -> DONE; done pulses 2 cycles after the request; totals are 0.
- Refill: accepted when refill_valid && refill_ready.
  - count[sel] = min(count + qty, 2^CNT_W - 1) (saturating).
  - A refill also clears fault[sel].
  - Refill and change_req in the same IDLE cycle: both are accepted; SELECT sees the refilled count.
- Arithmetic: remaining never underflows, because the greedy rule guarantees denom <= remaining. The 50-denomination constant is zero-extended to AMT_W.

Decomposition:
- Shared package vend_pkg holds:
  - denomination constants DENOM_50/10/5/1;
  - hopper index constants;
  - state encoding.
- The vending FSM reuses the package's denominations.
- Sub-module vend_denom_select: combinational greedy picker. Inputs: remaining, counts, fault. Outputs: valid, index.

Test Plan:
1. Reset, request 66, ack 1 cycle after each req -> hopper_sel sequence 0,1,2,3; done; dispensed_total=66; shortfall=0; all counts=3.
2. After reset, request 27 -> sequence 1,1,2,3,3; dispensed_total=27; counts 4,2,3,2.
3. After reset, request 300 -> 4x50, 4x10, 4x5, 4x1; dispensed_total=264; shortfall=36; all counts=0; done pulses.
4. After reset, hopper 0 never acks, request 60 -> fault[0]=1 after TIMEOUT cycles; then 4x10, 4x5; dispensed_total=60; shortfall=0. A following refill of hopper 0 clears fault[0].
5. Request 66, then drop CLEAR low during the second DISPENSE -> all outputs return to reset values at once; counts=4; no done pulse.
6. In IDLE, refill hopper 3 with qty 255 together with change_req amount 0 -> count[3]=255 (saturated); done 2 cycles later; totals 0; refill_ready=0 while busy.
